// File: rtl/audio_pkg.sv
// audio_pkg: shared envelope state encoding and default envelope width
package audio_pkg;

    localparam int ENV_BITS_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

endpackage

// File: rtl/audio_env_fsm.sv
// audio_env_fsm: NOTE_ON edge detection plus ADSR state and saturating envelope level
module audio_env_fsm
    import audio_pkg::*;
#(
    parameter int ENV_BITS      = ENV_BITS_DEFAULT,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 1,
    parameter int SUSTAIN_LEVEL = 32,
    parameter int RELEASE_STEP  = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                NOTE_ON,
    input  logic                TICK,
    output logic [ENV_BITS-1:0] ENV_LEVEL,
    output logic                BUSY
);

    localparam logic [ENV_BITS:0]   LEVEL_MAX   = {1'b0, {ENV_BITS{1'b1}}};
    localparam logic [ENV_BITS:0]   ATTACK_INC  = (ENV_BITS+1)'(ATTACK_STEP);
    localparam logic [ENV_BITS:0]   DECAY_DEC   = (ENV_BITS+1)'(DECAY_STEP);
    localparam logic [ENV_BITS:0]   RELEASE_DEC = (ENV_BITS+1)'(RELEASE_STEP);
    localparam logic [ENV_BITS-1:0] SUSTAIN_VAL = ENV_BITS'(SUSTAIN_LEVEL);

    env_state_t          state, stateNext;
    logic [ENV_BITS-1:0] levelNext;
    logic                noteOnQ;
    logic                rise, fall;
    logic [ENV_BITS:0]   attackSum, decayDiff, releaseDiff;
    logic                attackTop, decayFloor, releaseFloor;

    // one extra bit so overflow and underflow are visible before saturating
    assign attackSum    = {1'b0, ENV_LEVEL} + ATTACK_INC;
    assign decayDiff    = {1'b0, ENV_LEVEL} - DECAY_DEC;
    assign releaseDiff  = {1'b0, ENV_LEVEL} - RELEASE_DEC;
    assign attackTop    = attackSum >= LEVEL_MAX;
    assign decayFloor   = decayDiff[ENV_BITS] || (decayDiff <= {1'b0, SUSTAIN_VAL});
    assign releaseFloor = releaseDiff[ENV_BITS] || (releaseDiff == '0);

    assign rise = NOTE_ON && !noteOnQ;
    assign fall = !NOTE_ON && noteOnQ;
    assign BUSY = state != IDLE;

    // register NOTE_ON history, ADSR state and level
    always_ff @(posedge CLK) begin
        if (RESET) begin
            noteOnQ   <= 1'b0;
            state     <= IDLE;
            ENV_LEVEL <= '0;
        end else begin
            noteOnQ   <= NOTE_ON;
            state     <= stateNext;
            ENV_LEVEL <= levelNext;
        end
    end

    // note edges take priority over ticks; a retrigger keeps the current level
    always_comb begin
        stateNext = state;
        levelNext = ENV_LEVEL;
        if (rise)
            stateNext = ATTACK;
        else if (fall && (state inside {ATTACK, DECAY, SUSTAIN}))
            stateNext = RELEASE;
        else if (TICK) begin
            case (state)
                ATTACK: begin
                    stateNext = attackTop ? DECAY : ATTACK;
                    levelNext = attackTop ? '1 : attackSum[ENV_BITS-1:0];
                end
                DECAY: begin
                    stateNext = decayFloor ? SUSTAIN : DECAY;
                    levelNext = decayFloor ? SUSTAIN_VAL : decayDiff[ENV_BITS-1:0];
                end
                RELEASE: begin
                    stateNext = releaseFloor ? IDLE : RELEASE;
                    levelNext = releaseFloor ? '0 : releaseDiff[ENV_BITS-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/generic_counter.sv
// GenericCounter: wrapping 0..COUNTER_MAX counter emitting a one-cycle TICK on its last count
module GenericCounter #(
    parameter int COUNTER_WIDTH = 16,
    parameter int COUNTER_MAX   = 65535
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    output logic TICK
);

    localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(COUNTER_MAX);

    logic [COUNTER_WIDTH-1:0] count;

    assign TICK = ENABLE && (count == LAST);

    // free-running count, wraps to zero after LAST
    always_ff @(posedge CLK) begin
        if (RESET)
            count <= '0;
        else if (ENABLE)
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/audio_envelope_pwm.sv
// audio_envelope_pwm: ADSR-enveloped, PWM-gated square wave output stage
// Build option AUDIO_ENV_PDM_EN: compare against bit-reversed PWM counter (pulse-density output).
module audio_envelope_pwm
    import audio_pkg::*;
#(
    parameter int ENV_BITS      = ENV_BITS_DEFAULT,
    parameter int ENV_TICK_DIV  = 48828,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 1,
    parameter int SUSTAIN_LEVEL = 32,
    parameter int RELEASE_STEP  = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                AUDIO_IN,
    input  logic                NOTE_ON,
    output logic                AUDIO_OUT,
    output logic [ENV_BITS-1:0] ENV_LEVEL,
    output logic                BUSY
);

    logic                envTick;
    logic [ENV_BITS-1:0] pwmCnt, cmp;

    GenericCounter #(
        .COUNTER_WIDTH(16),
        .COUNTER_MAX  (ENV_TICK_DIV - 1)
    ) tickGen (
        .CLK   (CLK),
        .RESET (RESET),
        .ENABLE(1'b1),
        .TICK  (envTick)
    );

    audio_env_fsm #(
        .ENV_BITS     (ENV_BITS),
        .ATTACK_STEP  (ATTACK_STEP),
        .DECAY_STEP   (DECAY_STEP),
        .SUSTAIN_LEVEL(SUSTAIN_LEVEL),
        .RELEASE_STEP (RELEASE_STEP)
    ) envFsm (
        .CLK      (CLK),
        .RESET    (RESET),
        .NOTE_ON  (NOTE_ON),
        .TICK     (envTick),
        .ENV_LEVEL(ENV_LEVEL),
        .BUSY     (BUSY)
    );

`ifdef AUDIO_ENV_PDM_EN
    assign cmp = {<<{pwmCnt}};
`else
    assign cmp = pwmCnt;
`endif

    // free-running PWM counter and registered gated output
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pwmCnt    <= '0;
            AUDIO_OUT <= 1'b0;
        end else begin
            pwmCnt    <= pwmCnt + 1'b1;
            AUDIO_OUT <= AUDIO_IN && (cmp < ENV_LEVEL);
        end
    end

endmodule
